serial_bus_port: RTL and testbench
==================================

# serial_bus_port

Parametrised serial bus interface for the core. It moves DATA_W-bit words over the BUS_W-bit external bus in DATA_W/BUS_W beats, in both directions. It replaces the fixed 16-bit/8-bit, three-source output mux and separate shift registers with one arbitrated, handshaked port serving NCH transmit channels (PC, MAR and MDR at defaults) plus one receive path (instruction/data fetch). It adds a beat-level timeout and protocol-error detection.

## Interface
Parameters:
- DATA_W, 16, word width; must be a multiple of BUS_W.
- BUS_W, 8, external bus width.
- NCH, 3, transmit channels; channel index = priority (0 highest).
- TIMEOUT, 0, idle cycles allowed between beats before abort; 0 disables.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- tx_req  in  NCH  per-channel send request, level, held until tx_done.
- tx_data  in  NCH*DATA_W  per-channel word; channel i at [i*DATA_W +: DATA_W].
- tx_grant  out  NCH  one-hot channel captured for current send.
- tx_done  out  1  one-cycle pulse; granted word fully accepted.
- rx_start  in  1  request to receive one word.
- rx_data  out  DATA_W  last completed received word.
- rx_valid  out  1  one-cycle pulse; rx_data updated.
- ard_data_ready  in  1  in_bus carries a valid beat this cycle.
- ard_receive_ready  in  1  external side accepts out_bus beat this cycle.
- in_bus  in  BUS_W  inbound beat.
- out_bus  out  BUS_W  outbound beat.
- bus_sel  out  NCH  one-hot channel currently driving out_bus (successor of bus_pc/bus_mdr/bus_mar).
- busy  out  1  state != IDLE.
- error  out  1  sticky protocol/timeout error.

## Operation
- BEATS = DATA_W/BUS_W. Beat order: MSB beat first, both directions.
- States: IDLE, SEND, RECV.
- IDLE:
  - If rx_start, go to RECV. rx_start has priority over any tx_req.
  - Else if any tx_req, grant the lowest set index, capture its tx_data into the shift register, and go to SEND.
- SEND:
  - out_bus = top BUS_W bits of the shift register; bus_sel = tx_grant.
  - A beat completes on a cycle with ard_receive_ready=1; the register then shifts left by BUS_W.
  - After beat BEATS completes: go to IDLE and pulse tx_done.
  - tx_req changes after capture do not affect the word being sent.
- RECV:
  - Each cycle with ard_data_ready=1 shifts in_bus into the LSB end (shift left by BUS_W).
  - After beat BEATS: load rx_data, pulse rx_valid, go to IDLE.
- Outside SEND: out_bus=0, bus_sel=0, tx_grant=0.
- Protocol error: ard_data_ready=1 while not in RECV sets error; the beat is discarded. ard_receive_ready outside SEND is ignored.
- Timeout (TIMEOUT>0):
  - Beat-gap counter clears on entry to SEND/RECV and on every completed beat.
  - Reaching TIMEOUT sets error and returns to IDLE with no tx_done/rx_valid. rx_data is unchanged.
- error is cleared only by rst. The port keeps operating while error=1.

## Timing
- Reset values: state IDLE; all outputs 0, including rx_data and error.
- Request seen in IDLE at cycle t: state SEND/RECV, tx_grant and bus_sel valid at t+1. First beat may complete at t+1.
- tx_done and rx_valid are registered: high in the cycle after the last beat, coincident with IDLE.
- Back-to-back transfers: a new grant is decided in that IDLE cycle, so minimum transfer period is BEATS+1 cycles.
- Reset during SEND/RECV: return to reset values next cycle. No done/valid pulse; partial word discarded.

## Structure
- Shared package: bus_state_t enum (IDLE, SEND, RECV). Reuse the existing error/ctrl typedefs unchanged.
- One sub-module: bus_word_shifter, a DATA_W-bit register with parallel load, left shift by BUS_W, BUS_W serial in/out. It is instantiated once and shared by SEND and RECV.
- Fixed-priority encoder and beat/timeout counters are inline, with widths from $clog2.

## Test plan
- Defaults; tx_req=3'b010, ch1 data 16'hBEEF, ard_receive_ready=1 -> bus_sel=3'b010 for 2 cycles, out_bus 8'hBE then 8'hEF, tx_done one cycle later.
- rx_start; in_bus 8'h12 then 8'h34 with a 3-cycle ard_data_ready gap between beats -> rx_data=16'h1234, single rx_valid pulse.
- tx_req=3'b101 and rx_start together -> RECV first, then ch0 send, then ch2 send, each separated by one IDLE cycle.
- TIMEOUT=4, SEND with ard_receive_ready=0 -> error=1 after 4 cycles, state IDLE, no tx_done.
- ard_data_ready=1 in IDLE -> error=1, stays 1 through later good transfers, cleared by rst.
- rst after first beat of 16'hA55A -> all outputs 0 next cycle, no tx_done. Re-request sends 8'hA5, 8'h5A in full.

Source files
------------

// File: rtl/serial_bus_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_bus_port_pkg
// Description : Shared types and helpers for the serial bus port.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_bus_port_pkg;

  // Port sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2
  } bus_state_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_bus_port_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_bus_port_if
// Description : Handshake and bus signal bundle of the serial bus port.
//               slave  = the port itself, master = the core / external side.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_bus_port_if #(
  parameter int DATA_W = 16,
  parameter int BUS_W  = 8,
  parameter int NCH    = 3
);

  logic [NCH-1:0]        tx_req;
  logic [NCH*DATA_W-1:0] tx_data;
  logic [NCH-1:0]        tx_grant;
  logic                  tx_done;
  logic                  rx_start;
  logic [DATA_W-1:0]     rx_data;
  logic                  rx_valid;
  logic                  ard_data_ready;
  logic                  ard_receive_ready;
  logic [BUS_W-1:0]      in_bus;
  logic [BUS_W-1:0]      out_bus;
  logic [NCH-1:0]        bus_sel;
  logic                  busy;
  logic                  error;

  modport slave (
    input  tx_req, tx_data, rx_start, ard_data_ready, ard_receive_ready, in_bus,
    output tx_grant, tx_done, rx_data, rx_valid, out_bus, bus_sel, busy, error
  );

  modport master (
    output tx_req, tx_data, rx_start, ard_data_ready, ard_receive_ready, in_bus,
    input  tx_grant, tx_done, rx_data, rx_valid, out_bus, bus_sel, busy, error
  );

endinterface
`default_nettype wire

// File: rtl/serial_bus_port_shifter.sv
`default_nettype none
// ============================================================================
// Module      : bus_word_shifter
// Description : DATA_W-bit word register with parallel load and left shift by
//               BUS_W. The top BUS_W bits are the serial output; serial input
//               enters at the LSB end. Shared by transmit and receive.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_word_shifter #(
  parameter int DATA_W = 16,
  parameter int BUS_W  = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              load,
  input  wire logic [DATA_W-1:0] load_word,
  input  wire logic              shift,
  input  wire logic [BUS_W-1:0]  ser_in,
  output logic      [BUS_W-1:0]  ser_out,
  output logic      [DATA_W-1:0] shifted_word
);

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_d;

  // Word after one shift step; a single-beat word is simply replaced.
  generate
    if (DATA_W > BUS_W) begin : g_multi_beat
      assign shifted_word = {word_q[DATA_W-BUS_W-1:0], ser_in};
    end else begin : g_single_beat
      assign shifted_word = ser_in;
    end
  endgenerate

  assign ser_out = word_q[DATA_W-1 -: BUS_W];

  // Load has precedence over shift; the port never asserts both.
  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = load_word;
    end else if (shift) begin
      word_d = shifted_word;
    end
  end

  // Word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_bus_port.sv
`default_nettype none
// ============================================================================
// Module      : serial_bus_port
// Description : Arbitrated, handshaked serial port. Sends DATA_W-bit words from
//               NCH prioritised channels and receives DATA_W-bit words, MSB
//               beat first, over a BUS_W-bit bus. Optional beat-gap timeout
//               and sticky protocol-error flag. DATA_W must be a multiple of
//               BUS_W.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_bus_port
  import serial_bus_port_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int BUS_W   = 8,
  parameter int NCH     = 3,
  parameter int TIMEOUT = 0
) (
  input wire logic         clk,
  input wire logic         rst,
  serial_bus_port_if.slave bus
);

  localparam int BEATS = DATA_W / BUS_W;
  localparam int BEAT_W = cnt_width(BEATS);
  localparam int GAP_W = cnt_width(TIMEOUT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  bus_state_t        state_q, state_d;
  logic [NCH-1:0]    grant_q, grant_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              tx_done_q, tx_done_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              error_q, error_d;

  logic [NCH-1:0]    sel_oh;
  logic [DATA_W-1:0] sel_word;
  logic              sh_load;
  logic              sh_shift;
  logic [BUS_W-1:0]  sh_in;
  logic [BUS_W-1:0]  sh_out;
  logic [DATA_W-1:0] sh_shifted;

  bus_word_shifter #(
    .DATA_W (DATA_W),
    .BUS_W  (BUS_W)
  ) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .load         (sh_load),
    .load_word    (sel_word),
    .shift        (sh_shift),
    .ser_in       (sh_in),
    .ser_out      (sh_out),
    .shifted_word (sh_shifted)
  );

  // Fixed-priority pick of the lowest requesting channel and its word.
  always_comb begin
    sel_oh   = '0;
    sel_word = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.tx_req[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_word  = bus.tx_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Sequencer: next state, beat/gap counting, shifter control and pulses.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    tx_done_d  = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    error_d    = error_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_in      = (state_q == RECV) ? bus.in_bus : '0;

    // An inbound beat outside a receive is a protocol error and is dropped.
    if (bus.ard_data_ready && (state_q != RECV)) begin
      error_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        beat_d  = '0;
        gap_d   = '0;
        grant_d = '0;
        if (bus.rx_start) begin
          state_d = RECV;
        end else if (|bus.tx_req) begin
          state_d = SEND;
          grant_d = sel_oh;
          sh_load = 1'b1;
        end
      end

      SEND: begin
        if (bus.ard_receive_ready) begin
          sh_shift = 1'b1;
          gap_d    = '0;
          if (beat_q == BEAT_LAST) begin
            state_d   = IDLE;
            grant_d   = '0;
            tx_done_d = 1'b1;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (TIMEOUT > 0) begin
          if (gap_q == GAP_LAST) begin
            state_d = IDLE;
            grant_d = '0;
            error_d = 1'b1;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      RECV: begin
        if (bus.ard_data_ready) begin
          sh_shift = 1'b1;
          gap_d    = '0;
          if (beat_q == BEAT_LAST) begin
            state_d    = IDLE;
            rx_data_d  = sh_shifted;
            rx_valid_d = 1'b1;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (TIMEOUT > 0) begin
          if (gap_q == GAP_LAST) begin
            state_d = IDLE;
            error_d = 1'b1;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      beat_q     <= '0;
      gap_q      <= '0;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      tx_done_q  <= tx_done_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      error_q    <= error_d;
    end
  end

  // grant_q is only non-zero while in SEND.
  assign bus.tx_grant = grant_q;
  assign bus.bus_sel  = grant_q;
  assign bus.out_bus  = (state_q == SEND) ? sh_out : '0;
  assign bus.tx_done  = tx_done_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_bus_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_bus_port
// Description : Directed self-checking bench for serial_bus_port. Main
//               instance uses defaults (no timeout); a second instance with
//               TIMEOUT=4 covers the beat-gap abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bus_port;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_bus_port_if #(.DATA_W(16), .BUS_W(8), .NCH(3)) bus ();
  serial_bus_port_if #(.DATA_W(16), .BUS_W(8), .NCH(3)) bus_t ();

  serial_bus_port #(.DATA_W(16), .BUS_W(8), .NCH(3), .TIMEOUT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_bus_port #(.DATA_W(16), .BUS_W(8), .NCH(3), .TIMEOUT(4)) dut_t (
    .clk (clk),
    .rst (rst),
    .bus (bus_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.tx_req = '0;              bus_t.tx_req = '0;
    bus.tx_data = '0;             bus_t.tx_data = '0;
    bus.rx_start = 1'b0;          bus_t.rx_start = 1'b0;
    bus.ard_data_ready = 1'b0;    bus_t.ard_data_ready = 1'b0;
    bus.ard_receive_ready = 1'b0; bus_t.ard_receive_ready = 1'b0;
    bus.in_bus = '0;              bus_t.in_bus = '0;
  endtask

  // Full two-beat send on channel ch of word w with the receiver always ready.
  task automatic send_word(input int ch, input logic [15:0] w, input string tag);
    logic [2:0] oh;
    oh = 3'b001 << ch;
    bus.tx_data[ch*16 +: 16] = w;
    bus.tx_req = oh;
    bus.ard_receive_ready = 1'b1;
    tick();
    check({tag, " sel0"}, 32'(bus.bus_sel), 32'(oh));
    check({tag, " beat0"}, 32'(bus.out_bus), 32'(w[15:8]));
    tick();
    check({tag, " beat1"}, 32'(bus.out_bus), 32'(w[7:0]));
    tick();
    check({tag, " done"}, 32'(bus.tx_done), 32'd1);
    bus.tx_req = '0;
    bus.ard_receive_ready = 1'b0;
    tick();
    check({tag, " done1"}, 32'(bus.tx_done), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    quiet_inputs();
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst busy",   32'(bus.busy), 32'd0);
    check("rst outbus", 32'(bus.out_bus), 32'd0);
    check("rst sel",    32'(bus.bus_sel), 32'd0);
    check("rst grant",  32'(bus.tx_grant), 32'd0);
    check("rst rxdata", 32'(bus.rx_data), 32'd0);
    check("rst err",    32'(bus.error), 32'd0);
    check("rst t busy", 32'(bus_t.busy), 32'd0);

    // Channel 1 send of BEEF.
    bus.tx_data[16 +: 16] = 16'hBEEF;
    bus.tx_req = 3'b010;
    bus.ard_receive_ready = 1'b1;
    tick();
    check("tx1 sel a",   32'(bus.bus_sel), 32'h2);
    check("tx1 grant",   32'(bus.tx_grant), 32'h2);
    check("tx1 out BE",  32'(bus.out_bus), 32'hBE);
    check("tx1 done a",  32'(bus.tx_done), 32'd0);
    tick();
    check("tx1 sel b",   32'(bus.bus_sel), 32'h2);
    check("tx1 out EF",  32'(bus.out_bus), 32'hEF);
    tick();
    check("tx1 done",    32'(bus.tx_done), 32'd1);
    check("tx1 idle sel", 32'(bus.bus_sel), 32'd0);
    check("tx1 idle",    32'(bus.busy), 32'd0);
    bus.tx_req = '0;
    bus.ard_receive_ready = 1'b0;
    tick();
    check("tx1 done off", 32'(bus.tx_done), 32'd0);
    check("tx1 out0",    32'(bus.out_bus), 32'd0);

    // Receive 1234 with a 3-cycle gap between beats.
    bus.rx_start = 1'b1;
    tick();
    bus.rx_start = 1'b0;
    check("rx busy", 32'(bus.busy), 32'd1);
    bus.ard_data_ready = 1'b1;
    bus.in_bus = 8'h12;
    tick();
    bus.ard_data_ready = 1'b0;
    bus.in_bus = 8'hFF;
    tick();
    tick();
    tick();
    check("rx gap busy",  32'(bus.busy), 32'd1);
    check("rx gap valid", 32'(bus.rx_valid), 32'd0);
    bus.ard_data_ready = 1'b1;
    bus.in_bus = 8'h34;
    tick();
    bus.ard_data_ready = 1'b0;
    check("rx valid",  32'(bus.rx_valid), 32'd1);
    check("rx data",   32'(bus.rx_data), 32'h1234);
    check("rx idle",   32'(bus.busy), 32'd0);
    tick();
    check("rx valid off", 32'(bus.rx_valid), 32'd0);
    check("rx noerr",  32'(bus.error), 32'd0);

    // rx_start beats tx_req; then ch0, then ch2.
    bus.tx_data = {16'h0304, 16'h9999, 16'h0102};
    bus.tx_req = 3'b101;
    bus.rx_start = 1'b1;
    tick();
    bus.rx_start = 1'b0;
    check("arb recv first", 32'(bus.busy), 32'd1);
    check("arb no grant",   32'(bus.tx_grant), 32'd0);
    bus.ard_data_ready = 1'b1;
    bus.in_bus = 8'hAB;
    tick();
    bus.in_bus = 8'hCD;
    tick();
    bus.ard_data_ready = 1'b0;
    check("arb rx data",  32'(bus.rx_data), 32'hABCD);
    check("arb rx idle",  32'(bus.busy), 32'd0);
    bus.ard_receive_ready = 1'b1;
    tick();
    check("arb ch0 grant", 32'(bus.tx_grant), 32'h1);
    check("arb ch0 b0",    32'(bus.out_bus), 32'h01);
    tick();
    check("arb ch0 b1",    32'(bus.out_bus), 32'h02);
    tick();
    check("arb ch0 done",  32'(bus.tx_done), 32'd1);
    check("arb gap idle",  32'(bus.busy), 32'd0);
    bus.tx_req = 3'b100;
    tick();
    check("arb ch2 grant", 32'(bus.tx_grant), 32'h4);
    check("arb ch2 b0",    32'(bus.out_bus), 32'h03);
    tick();
    check("arb ch2 b1",    32'(bus.out_bus), 32'h04);
    tick();
    check("arb ch2 done",  32'(bus.tx_done), 32'd1);
    bus.tx_req = '0;
    bus.ard_receive_ready = 1'b0;
    tick();

    // Timeout instance: receiver never ready.
    bus_t.tx_data[15:0] = 16'h1234;
    bus_t.tx_req = 3'b001;
    tick();
    check("to send", 32'(bus_t.busy), 32'd1);
    tick();
    tick();
    tick();
    check("to waiting", 32'(bus_t.busy), 32'd1);
    check("to no err yet", 32'(bus_t.error), 32'd0);
    tick();
    check("to err",    32'(bus_t.error), 32'd1);
    check("to idle",   32'(bus_t.busy), 32'd0);
    check("to nodone", 32'(bus_t.tx_done), 32'd0);
    check("to grant0", 32'(bus_t.tx_grant), 32'd0);
    bus_t.tx_req = '0;
    tick();

    // Protocol error in IDLE is sticky across good transfers.
    bus.ard_data_ready = 1'b1;
    bus.in_bus = 8'h77;
    tick();
    bus.ard_data_ready = 1'b0;
    check("perr set",  32'(bus.error), 32'd1);
    check("perr idle", 32'(bus.busy), 32'd0);
    send_word(2, 16'hC3D4, "perr tx");
    check("perr sticky", 32'(bus.error), 32'd1);

    // Reset mid-send of A55A.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perr cleared", 32'(bus.error), 32'd0);
    bus.tx_data[15:0] = 16'hA55A;
    bus.tx_req = 3'b001;
    bus.ard_receive_ready = 1'b1;
    tick();
    check("mr b0", 32'(bus.out_bus), 32'hA5);
    tick();
    check("mr b1", 32'(bus.out_bus), 32'h5A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr busy", 32'(bus.busy), 32'd0);
    check("mr out",  32'(bus.out_bus), 32'd0);
    check("mr sel",  32'(bus.bus_sel), 32'd0);
    check("mr done", 32'(bus.tx_done), 32'd0);
    tick();
    check("mr re b0",  32'(bus.out_bus), 32'hA5);
    check("mr re sel", 32'(bus.bus_sel), 32'h1);
    tick();
    check("mr re b1",  32'(bus.out_bus), 32'h5A);
    tick();
    check("mr re done", 32'(bus.tx_done), 32'd1);
    bus.tx_req = '0;
    bus.ard_receive_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
